// File: rtl/alu_operand_loader.sv
// Operand-entry front end: debounced ENTER/CLEAR keys step through
// opcode, A and B, then hold the operation until the ALU takes it.
module alu_operand_loader_key #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);
    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_prev;
    logic             r_arm;
    logic [1:0]       r_warm;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_done;

    assign w_differ = (r_s2 != r_stable);
    assign w_done   = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // r_arm stays low until a real released sample is seen, so a key held
    // through reset cannot fire when its debounced level first drops.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_stable <= 1'b1;
            r_prev   <= 1'b1;
            r_arm    <= 1'b0;
            r_warm   <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_s1   <= i_key_n;
            r_s2   <= r_s1;
            r_prev <= r_stable;
            r_warm <= {r_warm[0], 1'b1};
            if (r_warm[1] && r_s2)
                r_arm <= 1'b1;
            if (w_done) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_prev & ~r_stable & r_arm;
endmodule

module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [9:0] SW,
    input  logic       key_enter_n,
    input  logic       key_clear_n,
    input  logic       out_ready,
    output logic [1:0] op,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       out_valid,
    output logic [1:0] entry_state
);
    localparam logic [1:0] S_OP   = 2'd0;
    localparam logic [1:0] S_A    = 2'd1;
    localparam logic [1:0] S_B    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic       w_ent;
    logic       w_clr;
    logic [1:0] r_state;
    logic [1:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_valid;

    alu_operand_loader_key #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_enter (
        .i_clk   (CLOCK_50),
        .i_rst_n (resetn),
        .i_key_n (key_enter_n),
        .o_press (w_ent)
    );

    alu_operand_loader_key #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear (
        .i_clk   (CLOCK_50),
        .i_rst_n (resetn),
        .i_key_n (key_clear_n),
        .o_press (w_clr)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn || w_clr) begin
            r_state <= S_OP;
            r_op    <= 2'd0;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_OP: if (w_ent) begin
                    r_op    <= SW[9:8];
                    r_state <= S_A;
                end
                S_A: if (w_ent) begin
                    r_a     <= SW[3:0];
                    r_state <= S_B;
                end
                S_B: if (w_ent) begin
                    r_b     <= SW[3:0];
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                default: if (r_valid && out_ready) begin
                    r_valid <= 1'b0;
                    r_state <= S_OP;
                end
            endcase
        end
    end

    assign op          = r_op;
    assign a           = r_a;
    assign b           = r_b;
    assign out_valid   = r_valid;
    assign entry_state = r_state;
endmodule
